seven_segment_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the four-digit seven-segment display driver. Generates the 2-bit digit-select that scans the display at a fixed refresh rate and owns the four digit values presented to the driver. Digit updates arrive on a valid/ready handshake, are buffered in one pending slot, and are committed only at a frame boundary, so a scan never mixes old and new digits. Sits between the system's data producer (counter/FSM logic) and the combinational display driver.

---
 rtl/seven_segment_scan_ctrl_if.sv | 28 ++
 rtl/seven_segment_scan_ctrl.sv | 111 +++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_ctrl_if.sv
// Update handshake between the digit producer and the scan controller.
// The producer drives valid/digits; the controller returns ready.
interface seven_segment_scan_ctrl_if;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] upd_d1;
   logic [3:0] upd_d2;
   logic [3:0] upd_d3;
   logic [3:0] upd_d4;

   modport master (
      output upd_valid,
      output upd_d1,
      output upd_d2,
      output upd_d3,
      output upd_d4,
      input  upd_ready
   );

   modport slave (
      input  upd_valid,
      input  upd_d1,
      input  upd_d2,
      input  upd_d3,
      input  upd_d4,
      output upd_ready
   );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit display scan scheduler with a one-entry update slot committed at frame boundaries.
// Optional leading-zero blanking at commit: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic                      clk,
   input  logic                      rst_n,
   seven_segment_scan_ctrl_if.slave  upd_if,
   output logic [1:0]                enable_o,
   output logic [3:0]                digit1_o,
   output logic [3:0]                digit2_o,
   output logic [3:0]                digit3_o,
   output logic [3:0]                digit4_o,
   output logic                      frame_start_o
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       enable_q, enable_d;
   logic             frame_start_q, frame_start_d;
   logic             pend_full_q, pend_full_d;
   logic [15:0]      pend_q, pend_d;
   logic [3:0]       digit_q [4];
   logic [15:0]      commit_word;
   logic             tick;
   logic             frame_bound;
   logic             accept;
   logic             commit;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // Blank zeros in digits 1..3 from the left until the first nonzero digit.
   function automatic logic [15:0] shape_digits(input logic [15:0] s);
      logic [15:0] r;
      logic        lead;
      r    = s;
      lead = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (lead && (r[15-4*i -: 4] == 4'd0)) begin
            r[15-4*i -: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      return r;
   endfunction
`else
   function automatic logic [15:0] shape_digits(input logic [15:0] s);
      return s;
   endfunction
`endif

   assign tick        = (div_cnt_q == DIV_LAST);
   assign frame_bound = tick && (enable_q == 2'd3);
   assign upd_if.upd_ready = ~pend_full_q;
   assign accept      = upd_if.upd_valid && ~pend_full_q;
   // A boundary edge that also accepts cannot commit: the slot was empty.
   assign commit      = frame_bound && pend_full_q;
   assign commit_word = shape_digits(pend_q);

   always_comb begin
      div_cnt_d     = tick ? '0 : div_cnt_q + CNT_W'(1);
      enable_d      = tick ? enable_q + 2'd1 : enable_q;
      frame_start_d = frame_bound;
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      if (accept) begin
         pend_d      = {upd_if.upd_d1, upd_if.upd_d2, upd_if.upd_d3, upd_if.upd_d4};
         pend_full_d = 1'b1;
      end else if (commit) begin
         pend_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         enable_q      <= 2'd0;
         frame_start_q <= 1'b0;
         pend_full_q   <= 1'b0;
         pend_q        <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         enable_q      <= enable_d;
         frame_start_q <= frame_start_d;
         pend_full_q   <= pend_full_d;
         pend_q        <= pend_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               digit_q[gi] <= 4'hF;
            end else if (commit) begin
               digit_q[gi] <= commit_word[15-4*gi -: 4];
            end
         end
      end
   endgenerate

   assign enable_o      = enable_q;
   assign frame_start_o = frame_start_q;
   assign digit1_o      = digit_q[0];
   assign digit2_o      = digit_q[1];
   assign digit3_o      = digit_q[2];
   assign digit4_o      = digit_q[3];

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl with REFRESH_DIV=4 (frame = 16 cycles).
module tb_seven_segment_scan_ctrl;
   localparam int DIV = 4;
   localparam int CW  = 2;

   logic       clk;
   logic       rst_n;
   logic [1:0] enable;
   logic [3:0] digit1, digit2, digit3, digit4;
   logic       frame_start;

   int n_vec = 0;
   int n_err = 0;
   int k     = 0;   // rising edges since reset release

   seven_segment_scan_ctrl_if upd_if ();

   seven_segment_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .upd_if        (upd_if),
      .enable_o      (enable),
      .digit1_o      (digit1),
      .digit2_o      (digit2),
      .digit3_o      (digit3),
      .digit4_o      (digit4),
      .frame_start_o (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] digits();
      return {16'h0, digit1, digit2, digit3, digit4};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic goto_phase(input int ph);
      while ((k % 16) != ph) step();
   endtask

   task automatic drive(input logic v, input logic [15:0] d);
      upd_if.upd_valid = v;
      upd_if.upd_d1    = d[15:12];
      upd_if.upd_d2    = d[11:8];
      upd_if.upd_d3    = d[7:4];
      upd_if.upd_d4    = d[3:0];
   endtask

   task automatic send_commit(input string tag, input logic [15:0] v, input logic [15:0] exp);
      goto_phase(3);
      drive(1'b1, v);
      step();
      drive(1'b0, 16'h0);
      goto_phase(0);
      $display("update %h -> digits %h", v, digits());
      chk(tag, digits(), {16'h0, exp});
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      drive(1'b0, 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      k = 0;

      // reset state and scan sequence
      chk("rst_enable", enable, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_digits", digits(), 32'hFFFF);
      chk("rst_ready", upd_if.upd_ready, 1);
      for (int i = 0; i < 40; i++) begin
         step();
         chk("scan_enable", enable, (k / 4) % 4);
         chk("scan_fs", frame_start, (k % 16) == 0);
      end
      chk("scan_digits", digits(), 32'hFFFF);

      // basic update while enable=1
      goto_phase(5);
      chk("upd_en1", enable, 1);
      drive(1'b1, 16'h1234);
      step();
      drive(1'b0, 16'h0);
      chk("upd_ready_low", upd_if.upd_ready, 0);
      goto_phase(15);
      chk("upd_before", digits(), 32'hFFFF);
      step();
      $display("update 1234 -> digits %h", digits());
      chk("upd_commit", digits(), 32'h1234);
      chk("upd_enable0", enable, 0);
      chk("upd_fs", frame_start, 1);
      chk("upd_ready_high", upd_if.upd_ready, 1);

      // back-pressure: 5678 then 9999 held valid
      goto_phase(2);
      drive(1'b1, 16'h5678);
      step();
      chk("bp_ready_low", upd_if.upd_ready, 0);
      drive(1'b1, 16'h9999);
      n = 0;
      while (upd_if.upd_ready == 1'b0 && n < 64) begin
         step();
         n++;
      end
      chk("bp_timeout", n < 64, 1);
      chk("bp_phase", k % 16, 0);
      chk("bp_first", digits(), 32'h5678);
      step();
      drive(1'b0, 16'h0);
      chk("bp_second_acc", upd_if.upd_ready, 0);
      goto_phase(15);
      chk("bp_hold", digits(), 32'h5678);
      step();
      $display("update 9999 -> digits %h", digits());
      chk("bp_second", digits(), 32'h9999);

      // collision: accept on the boundary edge
      goto_phase(15);
      chk("col_ready", upd_if.upd_ready, 1);
      drive(1'b1, 16'h4321);
      step();
      drive(1'b0, 16'h0);
      chk("col_same_frame", digits(), 32'h9999);
      chk("col_ready_low", upd_if.upd_ready, 0);
      goto_phase(15);
      chk("col_hold", digits(), 32'h9999);
      step();
      $display("update 4321 -> digits %h", digits());
      chk("col_commit", digits(), 32'h4321);

      // leading-zero handling
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      send_commit("lz_0000", 16'h0000, 16'hFFF0);
      send_commit("lz_0105", 16'h0105, 16'hF105);
      send_commit("lz_0070", 16'h0070, 16'hFF70);
`else
      send_commit("lz_0000", 16'h0000, 16'h0000);
      send_commit("lz_0105", 16'h0105, 16'h0105);
      send_commit("lz_0070", 16'h0070, 16'h0070);
`endif
      send_commit("pass_AB", 16'hAB0C, 16'hAB0C);

      // reset mid-frame with a pending update
      goto_phase(1);
      drive(1'b1, 16'h6666);
      step();
      drive(1'b0, 16'h0);
      goto_phase(9);
      chk("mid_enable2", enable, 2);
      chk("mid_pending", upd_if.upd_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_enable", enable, 0);
      chk("arst_fs", frame_start, 0);
      chk("arst_digits", digits(), 32'hFFFF);
      chk("arst_ready", upd_if.upd_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if ((k % 4) == 0) chk("post_enable", enable, (k / 4) % 4);
      end
      chk("post_digits", digits(), 32'hFFFF);
      chk("post_ready", upd_if.upd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
